// File: rtl/ql_video_pkg.sv
// rtl/ql_video_pkg.sv - shared screen-memory definitions for the QL video blocks
// Purpose: mode encoding, writer state enumeration, word-address width and
// colour bit positions, shared by the pixel writer and the display fetcher.
package ql_video_pkg;

  // Screen modes: 512x256 at 2 bpp (8 px/word), 256x256 at 3 bpp (4 px/word)
  typedef enum logic {
    MODE_512 = 1'b0,
    MODE_256 = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_CLR
  } state_e;

  // Screen word address width (byte address bits [14:1])
  localparam int ADDR_W = 14;

  // Bit positions inside the 3-bit {green, red, blue} colour
  localparam int COL_GREEN = 2;
  localparam int COL_RED   = 1;
  localparam int COL_BLUE  = 0;

endpackage

// File: rtl/ql_pixel_merge.sv
// rtl/ql_pixel_merge.sv - combinational insert of one pixel into a screen word
// Ports:
//   old_word  in  screen word before the write
//   mode      in  screen mode (selects layout)
//   p         in  pixel index within the word (mode 1 uses p[1:0] only)
//   colour    in  {green, red, blue}
//   new_word  out old_word with the addressed pixel replaced
module ql_pixel_merge
  import ql_video_pkg::*;
(
  input  logic [15:0] old_word,
  input  mode_e       mode,
  input  logic [2:0]  p,
  input  logic [2:0]  colour,
  output logic [15:0] new_word
);

  logic [3:0] g_idx;
  logic [3:0] r_idx;
  logic [3:0] b_idx;

  always_comb begin
    new_word = old_word;
    g_idx    = 4'd0;
    r_idx    = 4'd0;
    b_idx    = 4'd0;
    if (mode == MODE_512) begin
      // Green plane in the high byte, red plane in the low byte, one bit per pixel
      g_idx = 4'd15 - {1'b0, p};
      r_idx = 4'd7  - {1'b0, p};
      new_word[g_idx] = colour[COL_GREEN];
      new_word[r_idx] = colour[COL_RED];
    end else begin
      // Two bits per pixel per byte; the even high-byte bits are left alone
      g_idx = 4'd15 - {1'b0, p[1:0], 1'b0};
      r_idx = 4'd7  - {1'b0, p[1:0], 1'b0};
      b_idx = 4'd6  - {1'b0, p[1:0], 1'b0};
      new_word[g_idx] = colour[COL_GREEN];
      new_word[r_idx] = colour[COL_RED];
      new_word[b_idx] = colour[COL_BLUE];
    end
  end

endmodule

// File: rtl/ql_pixel_writer.sv
// rtl/ql_pixel_writer.sv - plots pixels / clears the QL screen through a shared memory port
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   mode                           screen mode sampled at command acceptance
//   cmd_valid/cmd_ready            command handshake (ready only when idle)
//   cmd_op, cmd_x, cmd_y, cmd_colour  0 = plot pixel, 1 = clear screen
//   mem_addr/mem_rd/mem_we/mem_wdata  request to the memory arbiter, held until mem_ack
//   mem_ack, mem_rdata             grant; read data one cycle after a granted read
//   done                           one-cycle completion pulse
module ql_pixel_writer
  import ql_video_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [2:0]        cmd_colour,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  mode_e             mode_q, mode_d;
  logic [2:0]        colour_q, colour_d;
  logic [2:0]        p_q, p_d;
  logic              skip_q, skip_d;

  mode_e             cmd_mode;
  logic [15:0]       plot_word;
  logic [8:0][15:0]  clr_chain;

  assign cmd_mode = mode_e'(mode);

  // Plot path: merge the pixel into the word read back from memory
  ql_pixel_merge u_plot_merge (
    .old_word (mem_rdata),
    .mode     (mode_q),
    .p        (p_q),
    .colour   (colour_q),
    .new_word (plot_word)
  );

  // Clear path: write the colour into every slot of an all-zero word.
  // Mode 1 only has four slots, so stages 4..7 simply repeat slots 0..3.
  assign clr_chain[0] = 16'h0000;
  for (genvar k = 0; k < 8; k++) begin : g_clr
    ql_pixel_merge u_clr_merge (
      .old_word (clr_chain[k]),
      .mode     (cmd_mode),
      .p        (3'(k)),
      .colour   (cmd_colour),
      .new_word (clr_chain[k+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    mode_d   = mode_q;
    colour_d = colour_q;
    p_d      = p_q;
    skip_d   = skip_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d   = cmd_mode;
          colour_d = cmd_colour;
          if (cmd_op) begin
            state_d = ST_CLR;
            cnt_d   = '0;
            addr_d  = '0;
            wdata_d = clr_chain[8];
          end else begin
            state_d = ST_RD;
            if (cmd_mode == MODE_512) begin
              addr_d = {cmd_y, cmd_x[8:3]};
              p_d    = cmd_x[2:0];
              skip_d = 1'b0;
            end else begin
              addr_d = {cmd_y, cmd_x[7:2]};
              p_d    = {1'b0, cmd_x[1:0]};
              skip_d = cmd_x[8];   // off-screen in 256-wide mode: no memory access
            end
          end
        end
      end
      ST_RD: begin
        if (skip_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (mem_ack) begin
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        wdata_d = plot_word;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_CLR: begin
        if (mem_ack) begin
          cnt_d  = cnt_q + ADDR_W'(1);
          addr_d = cnt_q + ADDR_W'(1);
          if (cnt_q == '1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      mode_q   <= MODE_512;
      colour_q <= '0;
      p_q      <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      colour_q <= colour_d;
      p_q      <= p_d;
      skip_q   <= skip_d;
    end
  end

  // Strobes decode straight from the state so reset removes them at once
  assign cmd_ready = (state_q == ST_IDLE);
  assign mem_rd    = (state_q == ST_RD) && !skip_q;
  assign mem_we    = (state_q == ST_WR) || (state_q == ST_CLR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ql_pixel_writer.sv
// tb/tb_ql_pixel_writer.sv - directed self-checking bench for ql_pixel_writer
module tb_ql_pixel_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [2:0]  cmd_colour;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        done;

  int tests_run = 0;
  int fails     = 0;

  ql_pixel_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_colour (cmd_colour),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One plot with a read-modify-write; the memory stalls 'stall' cycles on both requests
  task automatic do_plot(input string name, input logic md, input logic [8:0] x,
                         input logic [7:0] y, input logic [2:0] col,
                         input logic [15:0] old, input int stall,
                         input logic [13:0] exp_addr, input logic [15:0] exp_wdata);
    int n;
    cmd_valid = 1'b1; cmd_op = 1'b0; mode = md;
    cmd_x = x; cmd_y = y; cmd_colour = col;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s ready: got %b want 1", name, cmd_ready);
    end
    tick();
    // Scramble the inputs: the command in flight must not see these
    cmd_valid = 1'b0; mode = ~md; cmd_x = ~x; cmd_y = ~y; cmd_colour = ~col;
    n = 0;
    while (mem_rd !== 1'b1 && n < 8) begin tick(); n++; end
    for (int i = 0; i < stall; i++) begin
      tests_run++;
      if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr) begin
        fails++; $display("FAIL %s rd_hold[%0d]: rd=%b we=%b addr=%h want rd=1 we=0 addr=%h",
                          name, i, mem_rd, mem_we, mem_addr, exp_addr);
      end
      tick();
    end
    tests_run++;
    if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr) begin
      fails++; $display("FAIL %s rd_req: rd=%b we=%b addr=%h want rd=1 we=0 addr=%h",
                        name, mem_rd, mem_we, mem_addr, exp_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rdata = old;         // valid only in the cycle after the read grant
    tick();
    mem_rdata = 16'hA5A5;
    n = 0;
    while (mem_we !== 1'b1 && n < 8) begin tick(); n++; end
    for (int i = 0; i < stall; i++) begin
      tests_run++;
      if (mem_we !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
        fails++; $display("FAIL %s wr_hold[%0d]: we=%b rd=%b addr=%h data=%h want we=1 rd=0 addr=%h data=%h",
                          name, i, mem_we, mem_rd, mem_addr, mem_wdata, exp_addr, exp_wdata);
      end
      tick();
    end
    tests_run++;
    if (mem_we !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
      fails++; $display("FAIL %s wr_req: we=%b rd=%b addr=%h data=%h want we=1 rd=0 addr=%h data=%h",
                        name, mem_we, mem_rd, mem_addr, mem_wdata, exp_addr, exp_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || mem_we !== 1'b0) begin
      fails++; $display("FAIL %s done: done=%b we=%b want done=1 we=0", name, done, mem_we);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s after: done=%b ready=%b want done=0 ready=1", name, done, cmd_ready);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; mode = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_colour = '0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    tick(); tick();
    tests_run++;
    if (mem_rd !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
        mem_addr !== 14'h0 || mem_wdata !== 16'h0) begin
      fails++; $display("FAIL reset_outputs: rd=%b we=%b done=%b addr=%h data=%h want all 0",
                        mem_rd, mem_we, done, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_stray_ack;
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    tests_run++;
    if (mem_rd !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || mem_addr !== 14'h0) begin
      fails++; $display("FAIL stray_ack: rd=%b we=%b done=%b ready=%b addr=%h want 0 0 0 1 0",
                        mem_rd, mem_we, done, cmd_ready, mem_addr);
    end
  endtask

  task automatic test_plot_mode0;
    do_plot("m0_x5_y3", 1'b0, 9'd5, 8'd3, 3'b110, 16'h0000, 0, 14'h00C0, 16'h0404);
    // Right edge; blue must be ignored in mode 0
    do_plot("m0_x511_y255", 1'b0, 9'd511, 8'd255, 3'b001, 16'hFFFF, 0, 14'h3FFF, 16'hFEFE);
  endtask

  task automatic test_plot_mode1;
    do_plot("m1_x1_y0", 1'b1, 9'd1, 8'd0, 3'b011, 16'hFFFF, 0, 14'h0000, 16'hDFFF);
    do_plot("m1_x255_y255", 1'b1, 9'd255, 8'd255, 3'b111, 16'h0000, 0, 14'h3FFF, 16'h0203);
  endtask

  task automatic test_stall;
    do_plot("m0_stall5", 1'b0, 9'd13, 8'd200, 3'b100, 16'h1234, 5, 14'h3201, 16'h1630);
  endtask

  task automatic test_offscreen;
    int bad_mem;
    bad_mem = 0;
    cmd_valid = 1'b1; cmd_op = 1'b0; mode = 1'b1;
    cmd_x = 9'd300; cmd_y = 8'd10; cmd_colour = 3'b111;
    tick();                     // acceptance edge
    cmd_valid = 1'b0;
    if (mem_rd !== 1'b0 || mem_we !== 1'b0) bad_mem++;
    tests_run++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL offscreen_early_done: done=%b want 0", done);
    end
    tick();
    if (mem_rd !== 1'b0 || mem_we !== 1'b0) bad_mem++;
    tests_run++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL offscreen_done: done=%b want 1 two cycles after acceptance", done);
    end
    tick();
    if (mem_rd !== 1'b0 || mem_we !== 1'b0) bad_mem++;
    tests_run++;
    if (bad_mem !== 0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL offscreen_nomem: mem_cycles=%0d done=%b ready=%b want 0 0 1",
                        bad_mem, done, cmd_ready);
    end
  endtask

  task automatic test_clear_mode0;
    int writes, bad_addr, bad_data, rd_seen, dones, cyc, extra_we;
    logic [13:0] exp_a;
    writes = 0; bad_addr = 0; bad_data = 0; rd_seen = 0; dones = 0; cyc = 0; extra_we = 0;
    exp_a = 14'd0;
    cmd_valid = 1'b1; cmd_op = 1'b1; mode = 1'b0; cmd_colour = 3'b010;
    mem_ack = 1'b1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL clr0_ready: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0; cmd_colour = 3'b111; mode = 1'b1;
    while (dones == 0 && cyc < 17000) begin
      if (mem_rd) rd_seen++;
      if (mem_we) begin
        if (mem_addr !== exp_a) bad_addr++;
        if (mem_wdata !== 16'h00FF) bad_data++;
        writes++;
        exp_a = exp_a + 14'd1;
      end
      if (done) dones++;
      tick();
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      if (mem_we) extra_we++;
      tick();
    end
    mem_ack = 1'b0;
    tests_run++;
    if (writes !== 16384) begin
      fails++; $display("FAIL clr0_writes: got %0d want 16384", writes);
    end
    tests_run++;
    if (bad_addr !== 0 || bad_data !== 0) begin
      fails++; $display("FAIL clr0_content: bad_addr=%0d bad_data=%0d want 0 0", bad_addr, bad_data);
    end
    tests_run++;
    if (dones !== 1 || extra_we !== 0 || rd_seen !== 0) begin
      fails++; $display("FAIL clr0_done: dones=%0d extra_we=%0d reads=%0d want 1 0 0",
                        dones, extra_we, rd_seen);
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL clr0_ready_after: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_clear;
    int n, dones;
    n = 0; dones = 0;
    // Mode 1, colour green+blue: green at 15,13,11,9 and blue at 6,4,2,0
    cmd_valid = 1'b1; cmd_op = 1'b1; mode = 1'b1; cmd_colour = 3'b101;
    mem_ack = 1'b1;
    tick();
    cmd_valid = 1'b0;
    while (!(mem_we === 1'b1 && mem_addr === 14'd100) && n < 300) begin
      if (done) dones++;
      tick(); n++;
    end
    tests_run++;
    if (mem_we !== 1'b1 || mem_addr !== 14'd100 || mem_wdata !== 16'hAA55) begin
      fails++; $display("FAIL clr1_at100: we=%b addr=%0d data=%h want 1 100 aa55",
                        mem_we, mem_addr, mem_wdata);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (mem_we !== 1'b0 || mem_addr !== 14'h0 || done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_clear: we=%b addr=%h done=%b want 0 0 0", mem_we, mem_addr, done);
    end
    tick(); tick();
    if (done) dones++;
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
    end
    tests_run++;
    if (cmd_ready !== 1'b1 || mem_we !== 1'b0 || dones !== 0) begin
      fails++; $display("FAIL rst_release: ready=%b we=%b dones=%0d want 1 0 0", cmd_ready, mem_we, dones);
    end
    do_plot("post_reset_plot", 1'b0, 9'd5, 8'd3, 3'b110, 16'h0000, 1, 14'h00C0, 16'h0404);
  endtask

  initial begin
    test_reset();
    test_stray_ack();
    test_plot_mode0();
    test_plot_mode1();
    test_stall();
    test_offscreen();
    test_clear_mode0();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ql_pixel_writer.md
QL_PIXEL_WRITER -- requirements
Module: ql_pixel_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port mode, input, 1 bit: 0 = 512x256, 8 px/word, 2 bpp; 1 = 256x256, 4 px/word, 3 bpp.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the block accepts a command on a cycle where cmd_valid and cmd_ready are both 1.
REQ-006 SHALL have port cmd_op, input, 1 bit: 0 = plot one pixel, 1 = clear the whole screen.
REQ-007 SHALL have port cmd_x, input, 9 bits: pixel column.
REQ-008 SHALL have port cmd_y, input, 8 bits: pixel line.
REQ-009 SHALL have port cmd_colour, input, 3 bits: {green, red, blue}; blue is ignored in mode 0.
REQ-010 SHALL have port mem_addr, output, 14 bits [14:1]: screen word address.
REQ-011 SHALL have port mem_rd, output, 1 bit: read request.
REQ-012 SHALL have port mem_we, output, 1 bit: write request.
REQ-013 SHALL have port mem_wdata, output, 16 bits: write data.
REQ-014 SHALL have port mem_ack, input, 1 bit: the arbiter grants the request presented this cycle.
REQ-015 SHALL have port mem_rdata, input, 16 bits: valid exactly one cycle after an acknowledged mem_rd.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.

Function
REQ-017 SHALL assert cmd_ready only in IDLE.
REQ-018 SHALL register mode, cmd_op, cmd_x, cmd_y and cmd_colour at acceptance; later changes SHALL NOT affect the command in flight.
REQ-019 SHALL form word addresses as: mode 0 = {y, x[8:3]} with pixel index p = x[2:0]; mode 1 = {y, x[7:2]} with p = x[1:0].
REQ-020 SHALL use this mode 0 pixel layout: green at bit 15-p, red at bit 7-p.
REQ-021 SHALL use this mode 1 pixel layout: green at bit 15-2p, red at bit 7-2p, blue at bit 6-2p.
REQ-022 SHALL leave every bit not belonging to the addressed pixel unchanged.
REQ-023 SHALL run plot as a read-modify-write sequence through states IDLE -> RD -> RWAIT -> WR -> IDLE.
REQ-024 RD state: hold mem_rd=1 with the address until mem_ack.
REQ-025 RWAIT state: capture mem_rdata.
REQ-026 WR state: hold mem_we=1 with the merged word until mem_ack.
REQ-027 SHALL pulse done in the cycle after the write ack.
REQ-028 SHALL NOT access memory for a mode 1 plot with x >= 256; it SHALL return to IDLE and pulse done on the next cycle.
REQ-029 SHALL run clear through states IDLE -> CLR -> IDLE.
REQ-030 CLR state: a 14-bit counter from 0 to 16383 drives mem_addr with mem_we=1, advancing once per mem_ack.
REQ-031 SHALL, after the ack at address 16383, pulse done on the next cycle, and the counter SHALL wrap to 0.
REQ-032 SHALL use the clear word formed by writing the colour into every pixel slot under the rules of REQ-020/REQ-021; for example, mode 0 green-only gives 16'hFF00.
REQ-033 SHALL never assert mem_rd and mem_we together; mem_addr and mem_wdata SHALL stay stable while a request is unacknowledged.
REQ-034 SHALL treat an ack arriving while no request is asserted as having no effect.

Reset
REQ-035 SHALL, while reset_n=0, force state=IDLE, mem_rd=0, mem_we=0, done=0, mem_addr=0, mem_wdata=0, clear counter=0, and cmd_ready=1 once reset_n is released.
REQ-036 SHALL, if reset occurs during RD, RWAIT, WR or CLR, abandon the command with no done pulse; the memory may hold a partial clear.

Structure
REQ-037 SHALL place the mode encoding, the state enumeration, the address width (14) and the colour bit indices in shared package ql_video_pkg, which the display block also uses.
REQ-038 SHALL implement the word merge as sub-module ql_pixel_merge: purely combinational, inputs old word, mode, p and colour, output new word, shared by the plot and clear paths.

Verification
REQ-039 SHALL cover a mode 0 plot at (x=5, y=3, colour=3'b110) with old word 16'h0000: expect mem_addr=14'h00C0 and mem_wdata=16'h0404, then done.
REQ-040 SHALL cover a mode 1 plot at (x=1, y=0, colour=3'b011) with old word 16'hFFFF: expect mem_addr=0 and mem_wdata=16'hDFFF.
REQ-041 SHALL cover a mode 1 plot with x=300: expect no mem_rd or mem_we, and done exactly two cycles after acceptance.
REQ-042 SHALL cover mem_ack held low for 5 cycles during RD and during WR: mem_addr and mem_wdata stay stable and the sequence completes correctly.
REQ-043 SHALL cover a mode 0 clear with colour 3'b010 and mem_ack tied high: expect 16384 writes of 16'h00FF at addresses 0..16383, then a single done.
REQ-044 SHALL cover reset_n pulsed low mid-clear at address 100: expect mem_we to drop immediately, no done, cmd_ready=1 after release, and a new plot that executes normally.
